// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: consumes the EX/MEM register, runs one data-memory
// access per memory instruction over a variable-latency req/ack port, stalls
// upstream stages while the access is outstanding, and loads MEM/WB.
module mem_stage_ctrl #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic              wbs_in,
  input  logic              mm_in,
  input  logic              wm_in,
  input  logic              ni_in,
  input  logic              wme_in,
  input  logic [3:0]        reg_dest_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic              stall_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              valid_out,
  output logic              wbs_out,
  output logic              ni_out,
  output logic              wme_out,
  output logic [3:0]        reg_dest_out,
  output logic [DATA_W-1:0] wb_data_out,
  output logic              fwd_en,
  output logic              err_timeout
);

  typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;

  // Access in flight: address/data/direction plus the fields MEM/WB needs later.
  logic              we_q, we_d;
  logic              load_q, load_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic              pend_wbs_q, pend_wbs_d;
  logic              pend_ni_q, pend_ni_d;
  logic              pend_wme_q, pend_wme_d;
  logic [3:0]        pend_rd_q, pend_rd_d;

  // MEM/WB register and sticky error.
  logic              valid_out_q, valid_out_d;
  logic              wbs_out_q, wbs_out_d;
  logic              ni_out_q, ni_out_d;
  logic              wme_out_q, wme_out_d;
  logic [3:0]        reg_dest_out_q, reg_dest_out_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              err_q, err_d;

  logic              mem_op;
  logic              stall_c;

  assign mem_op = valid_in & (wm_in | mm_in);

  // State register and all datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      we_q           <= 1'b0;
      load_q         <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      alu_q          <= '0;
      pend_wbs_q     <= 1'b0;
      pend_ni_q      <= 1'b0;
      pend_wme_q     <= 1'b0;
      pend_rd_q      <= '0;
      valid_out_q    <= 1'b0;
      wbs_out_q      <= 1'b0;
      ni_out_q       <= 1'b0;
      wme_out_q      <= 1'b0;
      reg_dest_out_q <= '0;
      wb_data_q      <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      we_q           <= we_d;
      load_q         <= load_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      alu_q          <= alu_d;
      pend_wbs_q     <= pend_wbs_d;
      pend_ni_q      <= pend_ni_d;
      pend_wme_q     <= pend_wme_d;
      pend_rd_q      <= pend_rd_d;
      valid_out_q    <= valid_out_d;
      wbs_out_q      <= wbs_out_d;
      ni_out_q       <= ni_out_d;
      wme_out_q      <= wme_out_d;
      reg_dest_out_q <= reg_dest_out_d;
      wb_data_q      <= wb_data_d;
      err_q          <= err_d;
    end
  end

  // Next-state, MEM/WB load and stall decision.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    we_d           = we_q;
    load_d         = load_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    alu_d          = alu_q;
    pend_wbs_d     = pend_wbs_q;
    pend_ni_d      = pend_ni_q;
    pend_wme_d     = pend_wme_q;
    pend_rd_d      = pend_rd_q;
    valid_out_d    = valid_out_q;
    wbs_out_d      = wbs_out_q;
    ni_out_d       = ni_out_q;
    wme_out_d      = wme_out_q;
    reg_dest_out_d = reg_dest_out_q;
    wb_data_d      = wb_data_q;
    err_d          = err_q;
    stall_c        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (mem_op) begin
          // Load+store together is a store: load data is never selected.
          state_d     = ST_ACCESS;
          cnt_d       = '0;
          we_d        = wm_in;
          load_d      = mm_in & ~wm_in;
          addr_d      = alu_result_in[ADDR_W-1:0];
          wdata_d     = mem_data_in;
          alu_d       = alu_result_in;
          pend_wbs_d  = wbs_in;
          pend_ni_d   = ni_in;
          pend_wme_d  = wme_in;
          pend_rd_d   = reg_dest_in;
          valid_out_d = 1'b0;
          stall_c     = 1'b1;
        end else if (valid_in) begin
          valid_out_d    = 1'b1;
          wbs_out_d      = wbs_in;
          ni_out_d       = ni_in;
          wme_out_d      = wme_in;
          reg_dest_out_d = reg_dest_in;
          wb_data_d      = alu_result_in;
        end else begin
          valid_out_d = 1'b0;
        end
      end

      ST_ACCESS: begin
        stall_c = 1'b1;
        if (mem_ack) begin
          // Releasing stall here lets EX/MEM advance on the completing edge.
          stall_c        = 1'b0;
          state_d        = ST_IDLE;
          cnt_d          = '0;
          valid_out_d    = 1'b1;
          wbs_out_d      = pend_wbs_q;
          ni_out_d       = pend_ni_q;
          wme_out_d      = pend_wme_q;
          reg_dest_out_d = pend_rd_q;
          wb_data_d      = load_q ? mem_rdata : alu_q;
        end else if (cnt_q == TIMEOUT_CNT) begin
          // Abort: the instruction is dropped and the pipeline moves on.
          stall_c     = 1'b0;
          state_d     = ST_IDLE;
          cnt_d       = '0;
          valid_out_d = 1'b0;
          err_d       = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Stall is gated by reset so it drops with the asynchronous reset.
  assign stall_out    = rst_n & stall_c;
  assign mem_req      = (state_q == ST_ACCESS);
  assign mem_we       = mem_req & we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign valid_out    = valid_out_q;
  assign wbs_out      = wbs_out_q;
  assign ni_out       = ni_out_q;
  assign wme_out      = wme_out_q;
  assign reg_dest_out = reg_dest_out_q;
  assign wb_data_out  = wb_data_q;
  assign fwd_en       = valid_out_q & wbs_out_q;
  assign err_timeout  = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed steps followed by random
// instructions, checked against a transaction-level model of the memory stage.
module tb_mem_stage_ctrl;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              valid_in, wbs_in, mm_in, wm_in, ni_in, wme_in;
  logic [3:0]        reg_dest_in;
  logic [DATA_W-1:0] alu_result_in, mem_data_in;
  logic              stall_out, mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              valid_out, wbs_out, ni_out, wme_out;
  logic [3:0]        reg_dest_out;
  logic [DATA_W-1:0] wb_data_out;
  logic              fwd_en, err_timeout;

  int checks = 0;
  int errors = 0;
  int txn    = 0;
  logic exp_err = 1'b0;

  // dev_mem is the memory device the DUT talks to; ref_mem is what the
  // instruction stream says memory should contain.
  logic [DATA_W-1:0] dev_mem [1024];
  logic [DATA_W-1:0] ref_mem [1024];

  mem_stage_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .wbs_in(wbs_in), .mm_in(mm_in),
    .wm_in(wm_in), .ni_in(ni_in), .wme_in(wme_in), .reg_dest_in(reg_dest_in),
    .alu_result_in(alu_result_in), .mem_data_in(mem_data_in), .stall_out(stall_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .valid_out(valid_out), .wbs_out(wbs_out),
    .ni_out(ni_out), .wme_out(wme_out), .reg_dest_out(reg_dest_out),
    .wb_data_out(wb_data_out), .fwd_en(fwd_en), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One instruction presented from EX/MEM. ack_at = ACCESS cycle (1-based)
  // in which the memory acknowledges; 0 means it never does.
  // Called at posedge+1; returns at posedge+1 after MEM/WB has been loaded.
  task automatic do_op(input logic v, input logic wbs, input logic mm, input logic wm,
                       input logic ni, input logic wme, input logic [3:0] rd,
                       input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] sd,
                       input int ack_at, input logic stray_ack);
    logic              is_mem, is_load, acked;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] exp_wb;
    int                k, stalls, exp_stalls;
    is_mem  = v & (wm | mm);
    is_load = mm & ~wm;
    a       = alu[ADDR_W-1:0];
    valid_in = v; wbs_in = wbs; mm_in = mm; wm_in = wm; ni_in = ni; wme_in = wme;
    reg_dest_in = rd; alu_result_in = alu; mem_data_in = sd;
    mem_ack = is_mem ? 1'b0 : stray_ack;
    mem_rdata = 16'hDEAD;
    @(negedge clk);
    check("stall_first", stall_out, is_mem);
    check("req_idle", mem_req, 1'b0);
    stalls = stall_out ? 1 : 0;
    acked  = 1'b0;
    if (!is_mem) begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      check("valid_out_alu", valid_out, v);
      if (v) begin
        check("wb_data_alu", wb_data_out, alu);
        check("reg_dest_alu", reg_dest_out, rd);
        check("ctrl_alu", {wbs_out, ni_out, wme_out}, {wbs, ni, wme});
      end
      check("fwd_en_alu", fwd_en, v & wbs);
    end else begin
      k = 0;
      exp_stalls = (ack_at >= 1 && ack_at <= TIMEOUT + 1) ? ack_at : TIMEOUT + 1;
      while (k < TIMEOUT + 1 && !acked) begin
        @(posedge clk); #1;
        k++;
        mem_ack   = (k == ack_at);
        mem_rdata = dev_mem[mem_addr];
        @(negedge clk);
        check("mem_req", mem_req, 1'b1);
        check("mem_addr", mem_addr, a);
        check("mem_we", mem_we, wm);
        if (wm) check("mem_wdata", mem_wdata, sd);
        if (k == 1) check("bubble", valid_out, 1'b0);
        check("stall_access", stall_out, (k != ack_at) && (k != TIMEOUT + 1));
        if (stall_out) stalls++;
        if (mem_ack) begin
          acked = 1'b1;
          if (mem_we) dev_mem[mem_addr] = mem_wdata;
        end
      end
      check("stall_cycles", stalls, exp_stalls);
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (acked) begin
        exp_wb = is_load ? ref_mem[a] : alu;
        if (wm) ref_mem[a] = sd;
        check("valid_out_mem", valid_out, 1'b1);
        check("wb_data_mem", wb_data_out, exp_wb);
        check("reg_dest_mem", reg_dest_out, rd);
        check("ctrl_mem", {wbs_out, ni_out, wme_out}, {wbs, ni, wme});
        check("fwd_en_mem", fwd_en, wbs);
      end else begin
        exp_err = 1'b1;
        check("valid_out_drop", valid_out, 1'b0);
        check("fwd_en_drop", fwd_en, 1'b0);
      end
    end
    check("err_timeout", err_timeout, exp_err);
    check("req_after", mem_req, 1'b0);
    txn++;
    $display("txn %0d v=%0b mm=%0b wm=%0b addr=0x%0h alu=0x%0h sd=0x%0h ack_at=%0d acked=%0b wb=0x%0h",
             txn, v, mm, wm, a, alu, sd, ack_at, acked, wb_data_out);
  endtask

  initial begin
    logic [DATA_W-1:0] r_alu, r_sd, r_hi;
    logic [3:0]        r_rd;
    int                kind, lat, ad;

    for (int i = 0; i < 1024; i++) begin
      dev_mem[i] = 16'(i * 7 + 3);
      ref_mem[i] = 16'(i * 7 + 3);
    end
    dev_mem[5] = 16'hBEEF;
    ref_mem[5] = 16'hBEEF;

    rst_n = 1'b0;
    valid_in = 0; wbs_in = 0; mm_in = 0; wm_in = 0; ni_in = 0; wme_in = 0;
    reg_dest_in = 0; alu_result_in = 0; mem_data_in = 0; mem_ack = 0; mem_rdata = 0;
    #2;
    check("rst_valid_out", valid_out, 1'b0);
    check("rst_req_we_stall", {mem_req, mem_we, stall_out}, 3'b000);
    check("rst_err", err_timeout, 1'b0);
    check("rst_regs", {reg_dest_out, wb_data_out}, 20'h0);
    check("rst_addr_wdata", {mem_addr, mem_wdata}, 26'h0);
    check("rst_fwd", fwd_en, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // ALU op, load with ack in 3rd access cycle, store with same-cycle ack.
    do_op(1, 1, 0, 0, 0, 0, 4'd1, 16'h0002, 16'h0000, 0, 0);
    do_op(1, 1, 1, 0, 1, 0, 4'd2, 16'h0005, 16'h0000, 3, 0);
    do_op(1, 0, 0, 1, 0, 1, 4'd3, 16'h0003, 16'h0001, 1, 0);
    // Idle cycle with a stray ack, then a load that times out.
    do_op(0, 0, 0, 0, 0, 0, 4'd0, 16'h0000, 16'h0000, 0, 1);
    do_op(1, 1, 1, 0, 0, 0, 4'd4, 16'h0009, 16'h0000, 0, 0);
    do_op(1, 1, 0, 0, 0, 1, 4'd5, 16'h1234, 16'h0000, 0, 0);
    // Back-to-back store then load of the same address; load+store combined.
    do_op(1, 0, 0, 1, 0, 0, 4'd6, 16'h0040, 16'hCAFE, 1, 0);
    do_op(1, 1, 1, 0, 0, 0, 4'd7, 16'h0040, 16'h0000, 1, 0);
    do_op(1, 1, 1, 1, 0, 0, 4'd8, 16'h0041, 16'h5A5A, 2, 0);
    do_op(1, 1, 1, 0, 0, 0, 4'd9, 16'h0041, 16'h0000, TIMEOUT + 1, 0);

    // Reset asserted mid-access: outputs must drop without a clock edge.
    valid_in = 1; wbs_in = 1; mm_in = 1; wm_in = 0; alu_result_in = 16'h0007; mem_ack = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_req", mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_req", mem_req, 1'b0);
    check("async_stall", stall_out, 1'b0);
    check("async_valid", valid_out, 1'b0);
    check("async_err", err_timeout, 1'b0);
    exp_err = 1'b0;
    valid_in = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op(1, 1, 0, 0, 1, 1, 4'd10, 16'hA5A5, 16'h0000, 0, 0);

    // Random instruction stream.
    for (int n = 0; n < 60; n++) begin
      kind  = $urandom_range(0, 9);
      ad    = $urandom_range(0, 7);
      r_hi  = 16'($urandom_range(0, 63));
      r_alu = {r_hi[5:0], 10'(ad)};
      r_sd  = 16'($urandom);
      r_rd  = 4'($urandom_range(0, 15));
      lat   = $urandom_range(0, 19);
      if (lat == 0) lat = 0;
      else if (lat == 1) lat = TIMEOUT + 1;
      else lat = $urandom_range(1, 5);
      case (kind)
        0, 1, 2: do_op(1, 1'($urandom), 0, 0, 1'($urandom), 1'($urandom), r_rd, 16'($urandom), r_sd, 0, 1'($urandom));
        3, 4, 5: do_op(1, 1'($urandom), 1, 0, 1'($urandom), 1'($urandom), r_rd, r_alu, r_sd, lat, 0);
        6, 7:    do_op(1, 1'($urandom), 0, 1, 1'($urandom), 1'($urandom), r_rd, r_alu, r_sd, lat, 0);
        8:       do_op(1, 1'($urandom), 1, 1, 1'($urandom), 1'($urandom), r_rd, r_alu, r_sd, lat, 0);
        default: do_op(0, 1'($urandom), 1'($urandom), 1'($urandom), 0, 0, r_rd, r_alu, r_sd, 0, 1'($urandom));
      endcase
    end

    valid_in = 0;
    @(posedge clk); #1;
    check("final_idle_valid", valid_out, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-stage consumer of the Execute/Memory pipeline register.
- Accepts one instruction per cycle from the EX/MEM register outputs and performs the data-memory read or write it requests through a req/ack port of variable latency.
- Stalls upstream stages while an access is outstanding, then drives the Memory/Writeback register and a forwarding path back to Execute.

Parameters:
DATA_W, 16, datapath width (ALU result, store data, load data)
ADDR_W, 10, data-memory word-address width; address = alu_result_in[ADDR_W-1:0]
TIMEOUT, 15, maximum cycles to wait for mem_ack before aborting (1..255)

Ports:
clk  in  1  pipeline clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
valid_in  in  1  EX/MEM holds a live instruction
wbs_in  in  1  write-back-to-register enable
mm_in  in  1  write-back source: 1 = memory load data, 0 = ALU result
wm_in  in  1  store (write data memory)
ni_in  in  1  pass-through control bit
wme_in  in  1  pass-through control bit
reg_dest_in  in  4  destination register
alu_result_in  in  DATA_W  ALU result / effective address
mem_data_in  in  DATA_W  store data
stall_out  out  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle
mem_req  out  1  data-memory request
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_W  word address
mem_wdata  out  DATA_W  write data
mem_ack  in  1  memory completed request (same cycle or later)
mem_rdata  in  DATA_W  read data, valid when mem_ack=1
valid_out  out  1  MEM/WB holds a live instruction
wbs_out, ni_out, wme_out  out  1 each  registered pass-through
reg_dest_out  out  4  registered destination
wb_data_out  out  DATA_W  registered write-back value
fwd_en  out  1  combinational: forwarding value available (valid_out & wbs_out)
err_timeout  out  1  sticky: an access was aborted

Behaviour:
- Reset (rst_n=0, async): state IDLE; valid_out, wbs_out, ni_out, wme_out, mem_req, mem_we, stall_out, err_timeout = 0; reg_dest_out = 0; wb_data_out = 0; mem_addr = 0; mem_wdata = 0; timeout counter = 0.
- Memory op: valid_in & (wm_in | mm_in). Otherwise ALU op.
- IDLE:
  - valid_in=0 -> valid_out<=0 next edge.
  - ALU op -> 1-cycle latency; next edge loads MEM/WB with valid_out=1, wb_data_out=alu_result_in, and the pass-through fields.
  - Memory op -> latch addr, wdata, we=wm_in and control fields; go to ACCESS; valid_out<=0 (bubble); stall_out=1 combinationally in the same cycle.
- ACCESS:
  - mem_req=1 and stall_out=1 every cycle; mem_addr, mem_we, mem_wdata held constant.
  - mem_ack=1 -> next edge loads MEM/WB (wb_data_out = mem_rdata for loads, latched alu_result for stores), valid_out=1; return to IDLE.
  - Stall drops in the ack cycle, so EX/MEM advances on that same edge.
  - Counter increments each ACCESS cycle without ack. At count==TIMEOUT with no ack -> err_timeout<=1; go to IDLE with valid_out<=0 (instruction dropped); stall released.
- Load+store both set (wm_in=1, mm_in=1): treated as a store; wb_data_out = alu_result.
- mem_ack while in IDLE: ignored.
- Back-to-back memory ops: the second is accepted in the cycle after return to IDLE (min 2 cycles per memory op when ack is same-cycle).
- Forwarding: fwd_en is reg_dest_out/wb_data_out-qualified; wbs_out=0 or valid_out=0 -> fwd_en=0.
- Reset mid-ACCESS: mem_req drops immediately (async); in-flight access is abandoned; no MEM/WB update.
- err_timeout clears only on reset.

Test Plan:
- Reset, then ALU op valid_in=1, wbs=1, mm=0, wm=0, reg_dest=1, alu_result=0x0002 -> next edge valid_out=1, reg_dest_out=1, wb_data_out=0x0002, fwd_en=1, stall_out never 1.
- Load mm=1, alu_result=0x0005, mem_ack after 3 cycles with rdata=0xBEEF -> stall_out=1 for 3 cycles; mem_addr=5, mem_we=0; then wb_data_out=0xBEEF, valid_out=1.
- Store wm=1, wbs=0, alu_result=0x0003, mem_data=0x0001, same-cycle ack -> mem_req/mem_we=1 one cycle, mem_wdata=0x0001; valid_out=1, fwd_en=0.
- Load with no ack, TIMEOUT=15 -> stall_out=1 for 16 cycles (counter 0..15); then err_timeout=1 (sticky), valid_out=0, next ALU op accepted normally.
- Store then load back-to-back with same-cycle ack -> 2 accesses, each 2 cycles, ordered, load returns the stored value from the memory model.
- rst_n=0 asserted in ACCESS mid-wait -> mem_req, stall_out, valid_out = 0 without a clock edge; after release, state IDLE.
